// File: rtl/unique_run_extractor_pkg.sv
// unique_pkg: widths, FSM states and run-entry type shared by the unique-elements pipeline
package unique_pkg;
    localparam int N = 8;
    localparam int WORD_SIZE = 4;
    localparam int CNT_W = $clog2(N + 1);
    localparam int IDX_W = $clog2(N);
    typedef enum logic [1:0] {S_LOAD, S_SCAN, S_EMIT} state_t;
    typedef struct packed {
        logic [WORD_SIZE-1:0] value;
        logic [CNT_W-1:0] count;
    } entry_t;
endpackage

// File: rtl/unique_run_extractor_if.sv
// unique_run_extractor_if: input word stream, output run-entry stream and status
interface unique_run_extractor_if;
    import unique_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [WORD_SIZE-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic out_last;
    logic [CNT_W-1:0] uniq_total;
    logic busy;
    logic sort_err;
    modport slave (
        input in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count, out_last, uniq_total, busy, sort_err
    );
    modport master (
        output in_valid, in_data, out_ready,
        input in_ready, out_valid, out_data, out_count, out_last, uniq_total, busy, sort_err
    );
endinterface

// File: rtl/unique_run_extractor_buffer.sv
// run_entry_buffer: N-deep (value, count) register file with open/increment/read and entry count u
module run_entry_buffer
    import unique_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic open_new,
    input  logic inc,
    input  logic [WORD_SIZE-1:0] value,
    input  logic [IDX_W-1:0] rd_idx,
    output entry_t rd_entry,
    output logic [CNT_W-1:0] u
);
    entry_t ent [N];
    logic [IDX_W-1:0] wi, ci;
    assign wi = IDX_W'(u);
    assign ci = IDX_W'(u - CNT_W'(1));
    assign rd_entry = ent[rd_idx];
    always_ff @(posedge clk) begin
        if (rst || clr) u <= '0;
        else if (open_new) u <= u + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (open_new) ent[wi] <= '{value: value, count: CNT_W'(1)};
        else if (inc) ent[ci].count <= ent[ci].count + 1'b1;
    end
endmodule

// File: rtl/unique_run_extractor.sv
// unique_run_extractor: buffers N sorted words, compacts equal runs, streams (value, count) entries
// Optional UNIQ_CHECK_SORTED_EN: sticky sort_err when a word is smaller than its predecessor.
module unique_run_extractor
    import unique_pkg::*;
(
    input logic clk,
    input logic rst,
    unique_run_extractor_if.slave bus
);
    state_t state, state_n;
    logic [WORD_SIZE-1:0] mem [N];
    logic [IDX_W-1:0] wr, i, rd;
    logic [CNT_W-1:0] u;
    entry_t rd_entry;
    logic same, open_new, inc, clr, last, beat, load;
    assign load = state == S_LOAD && bus.in_valid;
    assign same = mem[i] == mem[i - IDX_W'(1)];
    assign last = CNT_W'(rd) == u - CNT_W'(1);
    assign beat = state == S_EMIT && bus.out_ready;
    assign clr = beat && last;
    assign open_new = state == S_SCAN && (i == '0 || !same);
    assign inc = state == S_SCAN && i != '0 && same;
    run_entry_buffer ueb (
        .clk(clk), .rst(rst), .clr(clr), .open_new(open_new), .inc(inc),
        .value(mem[i]), .rd_idx(rd), .rd_entry(rd_entry), .u(u)
    );
    always_ff @(posedge clk) state <= rst ? S_LOAD : state_n;
    always_comb begin
        state_n = state;
        if (load && wr == IDX_W'(N - 1)) state_n = S_SCAN;
        if (state == S_SCAN && i == IDX_W'(N - 1)) state_n = S_EMIT;
        if (clr) state_n = S_LOAD;
        bus.in_ready = state == S_LOAD;
        bus.out_valid = state == S_EMIT;
        bus.busy = state != S_LOAD;
        bus.out_data = bus.out_valid ? rd_entry.value : '0;
        bus.out_count = bus.out_valid ? rd_entry.count : '0;
        bus.out_last = bus.out_valid && last;
        bus.uniq_total = bus.out_valid ? u : '0;
    end
    always_ff @(posedge clk) begin
        if (load) mem[wr] <= bus.in_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            i <= '0;
            rd <= '0;
        end else begin
            if (load) wr <= wr == IDX_W'(N - 1) ? '0 : wr + 1'b1;
            i <= state == S_SCAN && i != IDX_W'(N - 1) ? i + 1'b1 : '0;
            rd <= clr ? '0 : beat ? rd + 1'b1 : rd;
        end
    end
`ifdef UNIQ_CHECK_SORTED_EN
    logic err;
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (state == S_SCAN && i != '0 && mem[i] < mem[i - IDX_W'(1)]) err <= 1'b1;
    end
    assign bus.sort_err = err;
`else
    assign bus.sort_err = 1'b0;
`endif
endmodule

// File: tb/tb_unique_run_extractor.sv
// tb_unique_run_extractor: directed frames with a scoreboard queue checked by an output monitor
module tb_unique_run_extractor;
    import unique_pkg::*;
    typedef struct {
        int d;
        int c;
        int l;
        int t;
    } exp_t;
`ifdef UNIQ_CHECK_SORTED_EN
    localparam int SE = 1;
`else
    localparam int SE = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tog = 1'b0;
    logic rdy = 1'b1;
    int cyc = 0;
    int beat_cyc = 0;
    int total = 0;
    int pass = 0;
    exp_t q[$];
    logic [3:0] frame [8];
    unique_run_extractor_if bif ();
    unique_run_extractor dut (.clk(clk), .rst(rst), .bus(bif));
    assign bif.out_ready = rdy;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #2;
        rdy = tog ? ~rdy : 1'b1;
    end
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    task automatic push(input int d, input int c, input int l, input int t);
        q.push_back('{d: d, c: c, l: l, t: t});
    endtask
    task automatic send();
        for (int k = 0; k < 8; k++) begin
            bif.in_data = frame[k];
            bif.in_valid = 1'b1;
            @(posedge clk);
            beat_cyc = cyc;
            #1;
        end
        bif.in_valid = 1'b0;
    endtask
    task automatic wait_valid();
        for (int k = 0; k < 40 && !bif.out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("out_valid_seen", int'(bif.out_valid), 1);
    endtask
    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", q.size(), 0);
    endtask
    // Monitor: pops on every accepted beat, and checks outputs hold across a stall
    logic stalled = 1'b0;
    int sd, sc, sl;
    always @(negedge clk) begin
        if (stalled) begin
            chk("hold_valid", int'(bif.out_valid), 1);
            chk("hold_data", int'(bif.out_data), sd);
            chk("hold_count", int'(bif.out_count), sc);
            chk("hold_last", int'(bif.out_last), sl);
        end
        stalled = !rst && bif.out_valid && !bif.out_ready;
        sd = int'(bif.out_data);
        sc = int'(bif.out_count);
        sl = int'(bif.out_last);
        if (!rst && bif.out_valid && bif.out_ready) begin
            if (q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("beat_data", int'(bif.out_data), e.d);
                chk("beat_count", int'(bif.out_count), e.c);
                chk("beat_last", int'(bif.out_last), e.l);
                chk("beat_total", int'(bif.uniq_total), e.t);
            end
        end
    end
    initial begin
        bif.in_valid = 1'b0;
        bif.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(bif.in_ready), 1);
        chk("rst_out_valid", int'(bif.out_valid), 0);
        chk("rst_busy", int'(bif.busy), 0);
        chk("rst_uniq_total", int'(bif.uniq_total), 0);
        chk("rst_out_last", int'(bif.out_last), 0);
        chk("rst_out_data", int'(bif.out_data), 0);
        chk("rst_out_count", int'(bif.out_count), 0);
        chk("rst_sort_err", int'(bif.sort_err), 0);
        // 1: two runs, latency from final input beat
        frame = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8};
        push(1, 4, 0, 2);
        push(8, 4, 1, 2);
        send();
        chk("scan_busy", int'(bif.busy), 1);
        chk("scan_in_ready", int'(bif.in_ready), 0);
        wait_valid();
        chk("first_valid_latency", cyc - beat_cyc, 9);
        drain();
        // 2: all equal
        frame = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        push(5, 8, 1, 1);
        send();
        drain();
        chk("post_frame_in_ready", int'(bif.in_ready), 1);
        chk("post_frame_busy", int'(bif.busy), 0);
        chk("post_frame_total", int'(bif.uniq_total), 0);
        // 3: all distinct, in_valid held with junk outside LOAD
        for (int k = 0; k < 8; k++) begin
            frame[k] = 4'(k);
            push(k, 1, int'(k == 7), 8);
        end
        send();
        bif.in_valid = 1'b1;
        bif.in_data = 4'd15;
        wait_valid();
        bif.in_valid = 1'b0;
        drain();
        // 4: consumer stalls every other cycle
        frame = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd9, 4'd9, 4'd9};
        push(2, 2, 0, 3);
        push(3, 3, 0, 3);
        push(9, 3, 1, 3);
        tog = 1'b1;
        send();
        drain();
        tog = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // 5: reset after the first output beat abandons the frame
        frame = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8};
        push(1, 4, 0, 2);
        send();
        drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", int'(bif.out_valid), 0);
        chk("rst_mid_in_ready", int'(bif.in_ready), 1);
        chk("rst_mid_total", int'(bif.uniq_total), 0);
        rst = 1'b0;
        frame = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd6};
        push(4, 7, 0, 2);
        push(6, 1, 1, 2);
        send();
        drain();
        // 6: order violation
        chk("sort_err_before", int'(bif.sort_err), 0);
        frame = '{4'd3, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        push(3, 1, 0, 2);
        push(1, 7, 1, 2);
        send();
        repeat (3) @(posedge clk);
        #1;
        chk("sort_err_scan_busy", int'(bif.busy), 1);
        chk("sort_err_scan", int'(bif.sort_err), SE);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("sort_err_sticky", int'(bif.sort_err), SE);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
